// File: rtl/lsh_pkg.sv
// ============================================================================
//  Module   : lsh_pkg
//  Purpose  : Shared types and helpers for the minhash signature bucket table.
//  Revision : 1.0
// ============================================================================
`default_nettype none

package lsh_pkg;

  localparam int LSH_KEY_W = 32;
  localparam int LSH_WI_W  = 32;
  localparam int LSH_GID_W = 8;

  typedef struct packed {
    logic [LSH_KEY_W-1:0] tag;
    logic [LSH_WI_W-1:0]  w_index;
    logic [LSH_GID_W-1:0] g_id;
  } entry_t;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_INSERT = 2'd1,
    ST_LOOKUP = 2'd2
  } state_t;

  // Low idx_w bits of the result are key[idx_w-1:0] ^ key[2*idx_w-1:idx_w];
  // callers truncate to their bucket index width.
  function automatic logic [LSH_KEY_W-1:0] bucket_idx(input logic [LSH_KEY_W-1:0] key,
                                                      input int unsigned          idx_w);
    return key ^ (key >> idx_w);
  endfunction

endpackage

`default_nettype wire

// File: rtl/bucket_ram.sv
// ============================================================================
//  Module   : bucket_ram
//  Purpose  : NBUCKETS x DEPTH entry storage with per-bucket fill counters.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module bucket_ram
  import lsh_pkg::*;
#(
  parameter int NBUCKETS = 64,
  parameter int DEPTH    = 8,
  parameter int IDX_W    = $clog2(NBUCKETS),
  parameter int SLOT_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  parameter int CNT_W    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_wr_en,
  input  logic [IDX_W-1:0] i_wr_idx,
  input  entry_t           i_wr_entry,
  output logic             o_wr_full,
  input  logic [IDX_W-1:0] i_rd_idx,
  input  logic [SLOT_W-1:0] i_rd_slot,
  output entry_t           o_rd_entry,
  input  logic [IDX_W-1:0] i_cnt_idx,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [CNT_W-1:0] c_depth = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] c_one   = CNT_W'(1);

  entry_t           r_mem [NBUCKETS][DEPTH];
  logic [CNT_W-1:0] r_cnt [NBUCKETS];
  logic [CNT_W-1:0] w_wr_cnt;
  logic             w_append;

  assign w_wr_cnt   = r_cnt[i_wr_idx];
  assign o_wr_full  = (w_wr_cnt == c_depth);
  assign w_append   = i_wr_en && !o_wr_full;
  assign o_rd_entry = r_mem[i_rd_idx][i_rd_slot];
  assign o_cnt      = r_cnt[i_cnt_idx];

  // Entry storage is never reset: a zero count already hides stale slots.
  always_ff @(posedge clk) begin
    if (w_append) begin
      r_mem[i_wr_idx][w_wr_cnt[SLOT_W-1:0]] <= i_wr_entry;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int b = 0; b < NBUCKETS; b++) begin
        r_cnt[b] <= '0;
      end
    end else if (w_append) begin
      r_cnt[i_wr_idx] <= w_wr_cnt + c_one;
    end
  end

endmodule

`default_nettype wire

// File: rtl/sig_bucket_table.sv
// ============================================================================
//  Module   : sig_bucket_table
//  Purpose  : Minhash signature table: S-lane inserts, streamed key lookups.
//  Revision : 1.0
// ============================================================================
`default_nettype none

module sig_bucket_table
  import lsh_pkg::*;
#(
  parameter int S        = 4,
  parameter int KEY_W    = 32,
  parameter int WI_W     = 32,
  parameter int GID_W    = 8,
  parameter int NBUCKETS = 64,
  parameter int DEPTH    = 8
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      wr_valid,
  output logic                      wr_ready,
  input  logic [S*KEY_W-1:0]        wr_sig,
  input  logic [WI_W-1:0]           wr_wi,
  input  logic [GID_W-1:0]          wr_gid,
  input  logic                      lk_valid,
  output logic                      lk_ready,
  input  logic [KEY_W-1:0]          lk_key,
  output logic                      hit_valid,
  output logic [WI_W-1:0]           hit_wi,
  output logic [GID_W-1:0]          hit_gid,
  output logic                      lk_done,
  output logic [$clog2(DEPTH+1)-1:0] lk_hit_cnt,
  output logic                      overflow
);

  localparam int IDX_W  = $clog2(NBUCKETS);
  localparam int SLOT_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W  = $clog2(DEPTH + 1);
  localparam int LANE_W = (S > 1) ? $clog2(S) : 1;

  localparam logic [CNT_W-1:0]  c_one       = CNT_W'(1);
  localparam logic [LANE_W-1:0] c_lane_one  = LANE_W'(1);
  localparam logic [LANE_W-1:0] c_lane_last = LANE_W'(S - 1);

  state_t              r_state, w_state_nxt;
  logic [S*KEY_W-1:0]  r_sig;
  logic [WI_W-1:0]     r_wi;
  logic [GID_W-1:0]    r_gid;
  logic [LANE_W-1:0]   r_lane;
  logic [KEY_W-1:0]    r_key;
  logic [IDX_W-1:0]    r_lk_idx;
  logic [CNT_W-1:0]    r_cnt, r_slot, r_hit_cnt;
  logic                r_hit_valid, r_lk_done, r_overflow;
  logic [WI_W-1:0]     r_hit_wi;
  logic [GID_W-1:0]    r_hit_gid;

  logic [KEY_W-1:0]    w_lane_key;
  logic [IDX_W-1:0]    w_wr_idx, w_lk_idx;
  logic                w_wr_en, w_wr_full, w_scan, w_match, w_last_lane, w_last_slot;
  logic [CNT_W-1:0]    w_cnt_val;
  entry_t              w_wr_entry, w_rd_entry;

  assign w_lane_key  = r_sig[r_lane*KEY_W +: KEY_W];
  assign w_wr_idx    = IDX_W'(bucket_idx(w_lane_key, IDX_W));
  assign w_lk_idx    = IDX_W'(bucket_idx(lk_key, IDX_W));
  assign w_wr_en     = (r_state == ST_INSERT);
  assign w_wr_entry  = '{tag: w_lane_key, w_index: r_wi, g_id: r_gid};
  assign w_last_lane = (r_lane == c_lane_last);
  assign w_scan      = (r_state == ST_LOOKUP) && (r_slot < r_cnt);
  assign w_match     = w_scan && (w_rd_entry.tag == r_key);
  // An empty bucket still occupies one LOOKUP cycle before finishing.
  assign w_last_slot = (r_cnt == '0) || (r_slot == r_cnt - c_one);

  bucket_ram #(
    .NBUCKETS (NBUCKETS),
    .DEPTH    (DEPTH),
    .IDX_W    (IDX_W),
    .SLOT_W   (SLOT_W),
    .CNT_W    (CNT_W)
  ) u_bucket_ram (
    .clk        (clk),
    .reset      (reset),
    .i_wr_en    (w_wr_en),
    .i_wr_idx   (w_wr_idx),
    .i_wr_entry (w_wr_entry),
    .o_wr_full  (w_wr_full),
    .i_rd_idx   (r_lk_idx),
    .i_rd_slot  (r_slot[SLOT_W-1:0]),
    .o_rd_entry (w_rd_entry),
    .i_cnt_idx  (w_lk_idx),
    .o_cnt      (w_cnt_val)
  );

  always_comb begin
    w_state_nxt = r_state;
    wr_ready    = 1'b0;
    lk_ready    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        wr_ready = 1'b1;
        lk_ready = !wr_valid;
        if (wr_valid)      w_state_nxt = ST_INSERT;
        else if (lk_valid) w_state_nxt = ST_LOOKUP;
      end
      ST_INSERT: if (w_last_lane) w_state_nxt = ST_IDLE;
      ST_LOOKUP: if (w_last_slot) w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state     <= ST_IDLE;
      r_sig       <= '0;
      r_wi        <= '0;
      r_gid       <= '0;
      r_lane      <= '0;
      r_key       <= '0;
      r_lk_idx    <= '0;
      r_cnt       <= '0;
      r_slot      <= '0;
      r_hit_cnt   <= '0;
      r_hit_valid <= 1'b0;
      r_hit_wi    <= '0;
      r_hit_gid   <= '0;
      r_lk_done   <= 1'b0;
      r_overflow  <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_hit_valid <= 1'b0;
      r_lk_done   <= 1'b0;
      if (r_state == ST_IDLE && wr_valid) begin
        r_sig  <= wr_sig;
        r_wi   <= wr_wi;
        r_gid  <= wr_gid;
        r_lane <= '0;
      end else if (r_state == ST_IDLE && lk_valid) begin
        // Bucket count is frozen here; later inserts cannot extend this scan.
        r_key     <= lk_key;
        r_lk_idx  <= w_lk_idx;
        r_cnt     <= w_cnt_val;
        r_slot    <= '0;
        r_hit_cnt <= '0;
      end
      if (r_state == ST_INSERT) begin
        r_lane <= r_lane + c_lane_one;
        if (w_wr_full) r_overflow <= 1'b1;
      end
      if (r_state == ST_LOOKUP) begin
        r_slot <= r_slot + c_one;
        if (w_match) begin
          r_hit_valid <= 1'b1;
          r_hit_wi    <= w_rd_entry.w_index;
          r_hit_gid   <= w_rd_entry.g_id;
          r_hit_cnt   <= r_hit_cnt + c_one;
        end
        if (w_last_slot) r_lk_done <= 1'b1;
      end
    end
  end

  assign hit_valid  = r_hit_valid;
  assign hit_wi     = r_hit_wi;
  assign hit_gid    = r_hit_gid;
  assign lk_done    = r_lk_done;
  assign lk_hit_cnt = r_hit_cnt;
  assign overflow   = r_overflow;

endmodule

`default_nettype wire

// File: tb/tb_sig_bucket_table.sv
// ============================================================================
//  Module   : tb_sig_bucket_table
//  Purpose  : Directed and randomized checks of sig_bucket_table vs a list model.
//  Revision : 1.0
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module tb_sig_bucket_table;

  localparam int S = 4, KEY_W = 32, WI_W = 32, GID_W = 8, NB = 64, DEPTH = 8;
  localparam int CNT_W = $clog2(DEPTH + 1);

  logic               clk = 1'b0;
  logic               reset = 1'b1;
  logic               wr_valid = 1'b0, lk_valid = 1'b0;
  logic               wr_ready, lk_ready, hit_valid, lk_done, overflow;
  logic [S*KEY_W-1:0] wr_sig = '0;
  logic [WI_W-1:0]    wr_wi = '0, hit_wi;
  logic [GID_W-1:0]   wr_gid = '0, hit_gid;
  logic [KEY_W-1:0]   lk_key = '0;
  logic [CNT_W-1:0]   lk_hit_cnt;

  sig_bucket_table #(.S(S), .KEY_W(KEY_W), .WI_W(WI_W), .GID_W(GID_W),
                     .NBUCKETS(NB), .DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_sig(wr_sig), .wr_wi(wr_wi), .wr_gid(wr_gid),
    .lk_valid(lk_valid), .lk_ready(lk_ready), .lk_key(lk_key),
    .hit_valid(hit_valid), .hit_wi(hit_wi), .hit_gid(hit_gid),
    .lk_done(lk_done), .lk_hit_cnt(lk_hit_cnt), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int n_vec = 0, n_miss = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference model: every accepted entry in arrival order.
  typedef struct { logic [31:0] key; logic [31:0] wi; logic [7:0] gid; } ent_t;
  ent_t store[$];
  bit   m_ovf = 1'b0;

  function automatic int m_bucket(input logic [31:0] k);
    return int'((k % 64) ^ ((k / 64) % 64));
  endfunction

  function automatic logic [127:0] pack4(input logic [31:0] a, b, c, d);
    return {d, c, b, a};
  endfunction

  task automatic model_insert(input logic [31:0] k, input logic [31:0] wi, input logic [7:0] gid);
    int c = 0;
    foreach (store[i]) if (m_bucket(store[i].key) == m_bucket(k)) c++;
    if (c >= DEPTH) m_ovf = 1'b1;
    else store.push_back('{key: k, wi: wi, gid: gid});
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
    store.delete();
    m_ovf = 1'b0;
    @(negedge clk);
  endtask

  task automatic do_write(input logic [127:0] sig, input logic [31:0] wi, input logic [7:0] gid,
                          input bit hold_lk, input logic [31:0] lkey);
    int n = 0;
    #1;
    while (!wr_ready && n < 40) begin @(negedge clk); #1; n++; end
    if (!wr_ready) check_eq("wr_accept_timeout", 0, 1);
    wr_valid = 1'b1; wr_sig = sig; wr_wi = wi; wr_gid = gid;
    if (hold_lk) begin
      lk_valid = 1'b1; lk_key = lkey;
      #1 check_eq("lk_ready_vs_wr", lk_ready, 0);
    end
    @(posedge clk);
    #1 wr_valid = 1'b0; wr_sig = {4{$urandom}}; wr_wi = $urandom;
    for (int i = 0; i < S; i++) model_insert(sig[i*32 +: 32], wi, gid);
    for (int k = 1; k <= S; k++) begin
      @(negedge clk);
      check_eq("wr_ready_busy", wr_ready, 0);
    end
    @(negedge clk);
    check_eq("wr_ready_back", wr_ready, 1);
    check_eq("overflow", overflow, m_ovf);
  endtask

  task automatic lookup_accept(input logic [31:0] key);
    int n = 0;
    lk_valid = 1'b1; lk_key = key;
    #1;
    while (!lk_ready && n < 40) begin @(negedge clk); #1; n++; end
    if (!lk_ready) check_eq("lk_accept_timeout", 0, 1);
    @(posedge clk);
    #1 lk_valid = 1'b0; lk_key = $urandom;
  endtask

  function automatic void bucket_list(input logic [31:0] key, output ent_t bl[$]);
    bl.delete();
    foreach (store[i]) if (m_bucket(store[i].key) == m_bucket(key)) bl.push_back(store[i]);
  endfunction

  task automatic lookup_check(input logic [31:0] key);
    ent_t bl[$];
    int   last, nhit = 0;
    bit   exp_hv;
    bucket_list(key, bl);
    last = 1 + ((bl.size() > 0) ? bl.size() : 1);
    for (int k = 1; k <= last; k++) begin
      @(negedge clk);
      exp_hv = (k >= 2) && (bl[k-2].key == key);
      check_eq("hit_valid", hit_valid, exp_hv);
      if (exp_hv) begin
        nhit++;
        check_eq("hit_wi", hit_wi, bl[k-2].wi);
        check_eq("hit_gid", hit_gid, bl[k-2].gid);
      end
      check_eq("lk_done", lk_done, k == last);
    end
    check_eq("lk_hit_cnt", lk_hit_cnt, nhit);
  endtask

  task automatic do_lookup(input logic [31:0] key);
    lookup_accept(key);
    lookup_check(key);
  endtask

  function automatic logic [31:0] rand_key();
    return $urandom_range(0, 31) + ($urandom_range(0, 3) << 6) + ($urandom_range(0, 1) << 20);
  endfunction

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    ent_t bl[$];
    do_reset();
    check_eq("rst_wr_ready", wr_ready, 1);
    check_eq("rst_lk_ready", lk_ready, 1);
    check_eq("rst_hit_valid", hit_valid, 0);
    check_eq("rst_hit_wi", hit_wi, 0);
    check_eq("rst_hit_gid", hit_gid, 0);
    check_eq("rst_lk_done", lk_done, 0);
    check_eq("rst_lk_hit_cnt", lk_hit_cnt, 0);
    check_eq("rst_overflow", overflow, 0);
    do_lookup(32'h1234);

    do_write(pack4(32'hA, 32'hB, 32'hC, 32'hD), 5, 1, 1'b0, 0);
    do_lookup(32'hB);

    // 0x1001 and 0x01 fold to the same bucket (bits above 2*IDX_W are ignored).
    do_reset();
    do_write(pack4(32'h1001, 32'h2, 32'h3, 32'h4), 3, 0, 1'b0, 0);
    do_write(pack4(32'h01, 32'h6, 32'h7, 32'h8), 7, 2, 1'b0, 0);
    do_lookup(32'h01);

    do_write(pack4(32'h20, 32'h21, 32'h22, 32'h23), 11, 4, 1'b1, 32'h22);
    do_lookup(32'h22);

    do_reset();
    for (int w = 0; w < 9; w++)
      do_write(pack4(32'h5, 8 + w*3, 9 + w*3, 10 + w*3), w, 8'(w), 1'b0, 0);
    do_lookup(32'h5);

    // Abort a 5-entry scan with reset during its third compare cycle.
    do_write(pack4(32'h30, 32'h30, 32'h30, 32'h30), 9, 3, 1'b0, 0);
    do_write(pack4(32'h30, 32'h31, 32'h32, 32'h33), 10, 3, 1'b0, 0);
    lookup_accept(32'h30);
    bucket_list(32'h30, bl);
    check_eq("bucket5_size", bl.size(), 5);
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      check_eq("mid_hit_valid", hit_valid, (k >= 2) && (bl[k-2].key == 32'h30));
      check_eq("mid_lk_done", lk_done, 0);
    end
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    store.delete();
    m_ovf = 1'b0;
    for (int k = 0; k < 6; k++) begin
      @(negedge clk);
      check_eq("abort_lk_done", lk_done, 0);
      check_eq("abort_hit_valid", hit_valid, 0);
      check_eq("abort_overflow", overflow, 0);
    end
    check_eq("abort_wr_ready", wr_ready, 1);
    do_lookup(32'h30);
    do_lookup(32'h5);

    do_reset();
    for (int it = 0; it < 60; it++) begin
      if ($urandom_range(0, 9) < 6) begin
        logic [31:0] lkey;
        bit hold;
        hold = ($urandom_range(0, 3) == 0);
        lkey = rand_key();
        do_write(pack4(rand_key(), rand_key(), rand_key(), rand_key()),
                 $urandom, 8'($urandom), hold, lkey);
        if (hold) do_lookup(lkey);
      end else begin
        do_lookup(rand_key());
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule

`default_nettype wire
